ifu_fetch_rsp: RTL and testbench
================================

Name: ifu_fetch_rsp

Overview:
Fetch responder that sits between the IFU and the IDU. It accepts a PC from the IFU over a valid/ready handshake and issues a single-beat read to instruction memory over a req/gnt/rvalid bus. It then presents the returned instruction, with its PC, to the IDU over a second valid/ready handshake. A jump from the EXU flushes any in-flight fetch; a flushed response is discarded, never forwarded.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, width of instruction word
NOP_INST, 32'h0000_0013, instruction substituted on error or misaligned fetch

Ports:
i_sys_clk  in  1  clock, rising edge
i_sys_rst_n  in  1  asynchronous active-low reset
i_ifu_valid  in  1  IFU presents a PC
o_rsp_ready  out  1  responder accepts a PC; drives the IFU's downstream-ready input
i_ifu_pc  in  ADDR_WIDTH  PC to fetch
i_exu_jmp_en  in  1  flush: discard current fetch/response
o_mem_req  out  1  memory read request
o_mem_addr  out  ADDR_WIDTH  read address
i_mem_gnt  in  1  request accepted this cycle
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  DATA_WIDTH  read data
i_mem_err  in  1  bus error, qualified by i_mem_rvalid
o_rsp_valid  out  1  instruction available to IDU
i_idu_ready  in  1  IDU accepts instruction
o_rsp_pc  out  ADDR_WIDTH  PC of presented instruction
o_rsp_inst  out  DATA_WIDTH  presented instruction
o_rsp_err  out  1  presented instruction is error/misaligned substitute
o_err_cnt  out  8  saturating count of error responses delivered

Behaviour:
- Reset (async assert, sync release): state IDLE, drop flag 0, o_mem_req 0, o_mem_addr 0, o_rsp_valid 0, o_rsp_pc 0, o_rsp_inst 0, o_rsp_err 0, o_err_cnt 0. Reset mid-transaction abandons it; any later rvalid in IDLE is ignored.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output except o_rsp_ready = (state==IDLE).
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: on i_ifu_valid && !i_exu_jmp_en, latch i_ifu_pc.
  - If pc[1:0]==0, go REQ.
  - Otherwise (misaligned) go HOLD with inst=NOP_INST and err=1; no memory access.
  - If i_exu_jmp_en is high, nothing is accepted that cycle.
- REQ: o_mem_req=1 and o_mem_addr=latched PC, held stable until i_mem_gnt. On gnt, go WAIT.
  - i_exu_jmp_en in REQ sets the drop flag. The request is not withdrawn; it stays asserted until gnt.
- WAIT: rvalid is legal no earlier than the cycle after gnt.
  - On i_mem_rvalid with drop=0: capture rdata (or NOP_INST if i_mem_err) and err=i_mem_err, then go HOLD.
  - On i_mem_rvalid with drop=1: discard the data, clear drop, go IDLE.
  - i_exu_jmp_en in WAIT sets drop. If it coincides with rvalid, the data is dropped.
- HOLD: o_rsp_valid=1; pc, inst and err stay stable while waiting.
  - On i_idu_ready: clear valid, go IDLE. If err=1, o_err_cnt increments and saturates at 255.
  - On i_exu_jmp_en: clear valid, go IDLE, no handoff and no count. Flush takes priority over a simultaneous i_idu_ready.
- Minimum latency: PC accepted at edge 0, req asserted cycle 1, gnt cycle 1, rvalid cycle 2, o_rsp_valid cycle 3. Peak throughput is one instruction per 4 cycles. One transaction is outstanding at most.
- i_mem_gnt or i_mem_rvalid outside REQ/WAIT respectively is ignored.

Test Plan:
- Basic fetch: reset, i_ifu_pc=0x8000_0000 valid, gnt in cycle 1, rvalid cycle 2 with rdata=0x0010_0093, idu_ready=1 -> o_rsp_valid in cycle 3 with pc=0x8000_0000, inst=0x0010_0093, err=0; o_rsp_ready back to 1 in cycle 4.
- Backpressure/stall: gnt delayed 3 cycles and idu_ready held low 5 cycles -> o_mem_req/o_mem_addr stable until gnt; o_rsp_* stable through HOLD; single handoff on ready.
- Flush in WAIT: jmp_en one cycle after gnt, rvalid 2 cycles later with 0xDEAD_BEEF -> o_rsp_valid never asserts, state IDLE, next fetch of 0x8000_0010 returns its own data.
- Flush coincident with rvalid, and flush coincident with idu_ready in HOLD -> no instruction delivered in either case, o_err_cnt unchanged.
- Error paths: rvalid with i_mem_err=1, then PC 0x8000_0002 -> both deliver inst=0x0000_0013, err=1, no mem_req for the misaligned PC; o_err_cnt=2. Then 260 error responses -> o_err_cnt=255.
- Async reset asserted while in WAIT, released, stale rvalid arrives -> ignored, all outputs 0, o_rsp_ready=1.

Source files
------------

// File: rtl/ifu_fetch_rsp.sv
// ifu_fetch_rsp: single-outstanding instruction fetch responder between IFU and IDU.
// Revision 1.0 - initial release.
`default_nettype none

module ifu_fetch_rsp #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INST   = 32'h0000_0013
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_ifu_valid,
  output logic                  o_rsp_ready,
  input  logic [ADDR_WIDTH-1:0] i_ifu_pc,
  input  logic                  i_exu_jmp_en,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_err,
  output logic                  o_rsp_valid,
  input  logic                  i_idu_ready,
  output logic [ADDR_WIDTH-1:0] o_rsp_pc,
  output logic [DATA_WIDTH-1:0] o_rsp_inst,
  output logic                  o_rsp_err,
  output logic [7:0]            o_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_drop;
  logic                  w_drop_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_err;
  logic [7:0]            r_err_cnt;
  logic                  w_accept;
  logic                  w_misaligned;
  logic                  w_capture;
  logic                  w_cnt_inc;

  assign w_misaligned = (i_ifu_pc[1:0] != 2'b00);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_ifu_valid && !i_exu_jmp_en) begin
          w_accept    = 1'b1;
          w_state_nxt = w_misaligned ? S_HOLD : S_REQ;
        end
      end
      S_REQ: begin
        // A flush cannot withdraw the request; the response is dropped later.
        if (i_exu_jmp_en) w_drop_nxt = 1'b1;
        if (i_mem_gnt)    w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          w_drop_nxt  = 1'b0;
          if (r_drop || i_exu_jmp_en) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end
        end else if (i_exu_jmp_en) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (i_exu_jmp_en) begin
          w_state_nxt = S_IDLE;
        end else if (i_idu_ready) begin
          w_state_nxt = S_IDLE;
          w_cnt_inc   = r_err;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_pc      <= '0;
      r_inst    <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      if (w_accept) begin
        r_pc <= i_ifu_pc;
        if (w_misaligned) begin
          r_inst <= NOP_INST;
          r_err  <= 1'b1;
        end
      end
      if (w_capture) begin
        r_inst <= i_mem_err ? NOP_INST : i_mem_rdata;
        r_err  <= i_mem_err;
      end
      if (w_cnt_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_rsp_ready = (r_state == S_IDLE);
  assign o_mem_req   = (r_state == S_REQ);
  assign o_mem_addr  = r_pc;
  assign o_rsp_valid = (r_state == S_HOLD);
  assign o_rsp_pc    = r_pc;
  assign o_rsp_inst  = r_inst;
  assign o_rsp_err   = r_err;
  assign o_err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch_rsp.sv
// tb_ifu_fetch_rsp: directed self-checking bench for ifu_fetch_rsp.
// Revision 1.0 - initial release.
`default_nettype none

module tb_ifu_fetch_rsp;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ifu_valid;
  logic        rsp_ready;
  logic [31:0] ifu_pc;
  logic        jmp_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        rsp_valid;
  logic        idu_ready;
  logic [31:0] rsp_pc;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_fetch_rsp #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NOP_INST   (32'h0000_0013)
  ) u_dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_ifu_valid  (ifu_valid),
    .o_rsp_ready  (rsp_ready),
    .i_ifu_pc     (ifu_pc),
    .i_exu_jmp_en (jmp_en),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .i_mem_gnt    (mem_gnt),
    .i_mem_rvalid (mem_rvalid),
    .i_mem_rdata  (mem_rdata),
    .i_mem_err    (mem_err),
    .o_rsp_valid  (rsp_valid),
    .i_idu_ready  (idu_ready),
    .o_rsp_pc     (rsp_pc),
    .o_rsp_inst   (rsp_inst),
    .o_rsp_err    (rsp_err),
    .o_err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int gnt_dly, input logic [31:0] rdata,
                          input logic err, input int rdy_dly, input logic [31:0] exp_inst);
    chk("idle_ready", {31'd0, rsp_ready}, 32'd1);
    ifu_valid = 1'b1; ifu_pc = pc;
    tick();
    ifu_valid = 1'b0; ifu_pc = 32'hFFFF_FFFC;
    chk("req_busy", {31'd0, rsp_ready}, 32'd0);
    for (int i = 0; i < gnt_dly; i++) begin
      chk("req_stall", {31'd0, mem_req}, 32'd1);
      chk("addr_stall", mem_addr, pc);
      tick();
    end
    chk("req", {31'd0, mem_req}, 32'd1);
    chk("addr", mem_addr, pc);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    chk("wait_valid", {31'd0, rsp_valid}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'hA5A5_A5A5; mem_err = 1'b0;
    for (int i = 0; i < rdy_dly; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_pc", rsp_pc, pc);
      chk("hold_inst", rsp_inst, exp_inst);
      tick();
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_pc", rsp_pc, pc);
    chk("rsp_inst", rsp_inst, exp_inst);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
    chk("handoff_valid", {31'd0, rsp_valid}, 32'd0);
    chk("handoff_ready", {31'd0, rsp_ready}, 32'd1);
  endtask

  task automatic misaligned_fetch(input logic [31:0] pc, input logic full_chk);
    ifu_valid = 1'b1; ifu_pc = pc;
    tick();
    ifu_valid = 1'b0;
    if (full_chk) begin
      chk("mis_req", {31'd0, mem_req}, 32'd0);
      chk("mis_valid", {31'd0, rsp_valid}, 32'd1);
      chk("mis_pc", rsp_pc, pc);
      chk("mis_inst", rsp_inst, C_NOP);
      chk("mis_err", {31'd0, rsp_err}, 32'd1);
    end
    idu_ready = 1'b1;
    tick();
    idu_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ifu_valid = 1'b0; ifu_pc = '0; jmp_en = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; idu_ready = 1'b0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, rsp_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic fetch at minimum latency
    do_fetch(32'h8000_0000, 0, 32'h0010_0093, 1'b0, 0, 32'h0010_0093);

    // Jump while valid in IDLE: nothing accepted
    ifu_valid = 1'b1; ifu_pc = 32'h8000_0004; jmp_en = 1'b1;
    tick();
    ifu_valid = 1'b0; jmp_en = 1'b0;
    chk("jmp_idle_ready", {31'd0, rsp_ready}, 32'd1);
    chk("jmp_idle_req", {31'd0, mem_req}, 32'd0);

    // Gnt delayed 3 cycles, IDU ready held low 5 cycles
    do_fetch(32'h8000_0004, 3, 32'h0020_0113, 1'b0, 5, 32'h0020_0113);

    // Flush one cycle after gnt, stale response two cycles later
    ifu_valid = 1'b1; ifu_pc = 32'h8000_0008;
    tick();
    ifu_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    jmp_en = 1'b1;
    tick();
    jmp_en = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("flushw_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flushw_ready", {31'd0, rsp_ready}, 32'd1);
    tick();
    chk("flushw_valid2", {31'd0, rsp_valid}, 32'd0);
    do_fetch(32'h8000_0010, 0, 32'h0030_0193, 1'b0, 1, 32'h0030_0193);

    // Flush coincident with rvalid
    ifu_valid = 1'b1; ifu_pc = 32'h8000_0014;
    tick();
    ifu_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; jmp_en = 1'b1;
    tick();
    mem_rvalid = 1'b0; jmp_en = 1'b0;
    chk("flushr_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flushr_ready", {31'd0, rsp_ready}, 32'd1);

    // Flush coincident with idu_ready on an error response
    ifu_valid = 1'b1; ifu_pc = 32'h8000_0018;
    tick();
    ifu_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222; mem_err = 1'b1;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    chk("flushh_pre", {31'd0, rsp_valid}, 32'd1);
    jmp_en = 1'b1; idu_ready = 1'b1;
    tick();
    jmp_en = 1'b0; idu_ready = 1'b0;
    chk("flushh_valid", {31'd0, rsp_valid}, 32'd0);
    chk("flushh_cnt", {24'd0, err_cnt}, 32'd0);

    // Error paths
    do_fetch(32'h8000_0020, 0, 32'h3333_3333, 1'b1, 0, C_NOP);
    chk("cnt_one", {24'd0, err_cnt}, 32'd1);
    misaligned_fetch(32'h8000_0002, 1'b1);
    chk("cnt_two", {24'd0, err_cnt}, 32'd2);
    for (int i = 0; i < 260; i++) misaligned_fetch(32'h8000_0001, 1'b0);
    chk("cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Async reset while waiting for data
    ifu_valid = 1'b1; ifu_pc = 32'h8000_0040;
    tick();
    ifu_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", {24'd0, err_cnt}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h4444_4444;
    tick();
    mem_rvalid = 1'b0;
    chk("stale_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stale_ready", {31'd0, rsp_ready}, 32'd1);
    chk("stale_req", {31'd0, mem_req}, 32'd0);
    chk("stale_pc", rsp_pc, 32'd0);
    chk("stale_inst", rsp_inst, 32'd0);
    chk("stale_err", {31'd0, rsp_err}, 32'd0);
    chk("stale_cnt", {24'd0, err_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
